// File: rtl/jtkcpu_alun.sv
// jtkcpu_alun: CPU ALU with single-cycle arithmetic/logic/shift ops and iterative MUL/DIV.
// Define JTKCPU_ALUN_DIV_EN to build the restoring divider for op 19; otherwise op 19 is undefined.
module jtkcpu_alun #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [4:0]   op,
    input  logic [W-1:0] opnd0,
    input  logic [W-1:0] opnd1,
    input  logic [7:0]   cc_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] rslt,
    output logic [W-1:0] rslt_hi,
    output logic [7:0]   cc_out
);

    localparam logic [4:0] OP_LD  = 5'd0;
    localparam logic [4:0] OP_ADD = 5'd1;
    localparam logic [4:0] OP_ADC = 5'd2;
    localparam logic [4:0] OP_SUB = 5'd3;
    localparam logic [4:0] OP_SBC = 5'd4;
    localparam logic [4:0] OP_AND = 5'd5;
    localparam logic [4:0] OP_OR  = 5'd6;
    localparam logic [4:0] OP_EOR = 5'd7;
    localparam logic [4:0] OP_NEG = 5'd8;
    localparam logic [4:0] OP_COM = 5'd9;
    localparam logic [4:0] OP_CLR = 5'd10;
    localparam logic [4:0] OP_INC = 5'd11;
    localparam logic [4:0] OP_DEC = 5'd12;
    localparam logic [4:0] OP_LSL = 5'd13;
    localparam logic [4:0] OP_LSR = 5'd14;
    localparam logic [4:0] OP_ASR = 5'd15;
    localparam logic [4:0] OP_ROL = 5'd16;
    localparam logic [4:0] OP_ROR = 5'd17;
    localparam logic [4:0] OP_MUL = 5'd18;
    localparam logic [4:0] OP_DIV = 5'd19;

    localparam logic [W-1:0] ZERO_W    = {W{1'b0}};
    localparam logic [W-1:0] ONE_W     = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] MIN_NEG   = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] MAX_POS   = {1'b0, {(W-1){1'b1}}};
    localparam logic [4:0]   LAST_STEP = 5'(W - 1);

    logic         busy_r, done_r;
    logic [W-1:0] rslt_r, rslt_hi_r, mcand_r, hi_r, lo_r;
    logic [7:0]   cc_r, cc_lat_r;
    logic [4:0]   step_r;
`ifdef JTKCPU_ALUN_DIV_EN
    logic         div_r;
    logic [W:0]   div_shift_s;
`endif

    logic [W-1:0] alu_rslt_s, alu_hi_s;
    logic [7:0]   alu_cc_s;
    logic         alu_multi_s;
    logic [W:0]   ext_s;
    logic [W:0]   mul_sum_s;
    logic [W-1:0] mul_hi_s, mul_lo_s, step_hi_s, step_lo_s;
    logic [7:0]   mul_cc_s, fin_cc_s;

    assign busy    = busy_r;
    assign done    = done_r;
    assign rslt    = rslt_r;
    assign rslt_hi = rslt_hi_r;
    assign cc_out  = cc_r;

    // Single-cycle result and flags, computed straight from the request inputs
    always_comb begin
        alu_rslt_s  = ZERO_W;
        alu_hi_s    = ZERO_W;
        alu_cc_s    = cc_in;
        alu_multi_s = 1'b0;
        ext_s       = {1'b0, ZERO_W};
        case (op)
            OP_LD:  begin alu_rslt_s = opnd0;          alu_cc_s[1] = 1'b0; end
            OP_AND: begin alu_rslt_s = opnd0 & opnd1;  alu_cc_s[1] = 1'b0; end
            OP_OR:  begin alu_rslt_s = opnd0 | opnd1;  alu_cc_s[1] = 1'b0; end
            OP_EOR: begin alu_rslt_s = opnd0 ^ opnd1;  alu_cc_s[1] = 1'b0; end
            OP_ADD, OP_ADC: begin
                ext_s = {1'b0, opnd0} + {1'b0, opnd1} + {ZERO_W, (op == OP_ADC) & cc_in[0]};
                alu_rslt_s  = ext_s[W-1:0];
                alu_cc_s[0] = ext_s[W];
                alu_cc_s[1] = (opnd0[W-1] == opnd1[W-1]) && (ext_s[W-1] != opnd0[W-1]);
                if (W == 8) begin
                    alu_cc_s[5] = opnd0[4] ^ opnd1[4] ^ ext_s[4];
                end else begin
                    alu_cc_s[5] = cc_in[5];
                end
            end
            OP_SUB, OP_SBC: begin
                // Bit W of the extended difference is the borrow
                ext_s = {1'b0, opnd0} - {1'b0, opnd1} - {ZERO_W, (op == OP_SBC) & cc_in[0]};
                alu_rslt_s  = ext_s[W-1:0];
                alu_cc_s[0] = ext_s[W];
                alu_cc_s[1] = (opnd0[W-1] != opnd1[W-1]) && (ext_s[W-1] != opnd0[W-1]);
            end
            OP_NEG: begin
                alu_rslt_s  = ZERO_W - opnd0;
                alu_cc_s[0] = (opnd0 != ZERO_W);
                alu_cc_s[1] = (opnd0 == MIN_NEG);
            end
            OP_COM: begin alu_rslt_s = ~opnd0; alu_cc_s[1] = 1'b0; alu_cc_s[0] = 1'b1; end
            OP_CLR: begin alu_rslt_s = ZERO_W; alu_cc_s[1] = 1'b0; alu_cc_s[0] = 1'b0; end
            OP_INC: begin alu_rslt_s = opnd0 + ONE_W; alu_cc_s[1] = (opnd0 == MAX_POS); end
            OP_DEC: begin alu_rslt_s = opnd0 - ONE_W; alu_cc_s[1] = (opnd0 == MIN_NEG); end
            OP_LSL: begin
                alu_rslt_s  = {opnd0[W-2:0], 1'b0};
                alu_cc_s[0] = opnd0[W-1];
                alu_cc_s[1] = opnd0[W-1] ^ opnd0[W-2];
            end
            OP_LSR: begin alu_rslt_s = {1'b0, opnd0[W-1:1]};       alu_cc_s[0] = opnd0[0]; end
            OP_ASR: begin alu_rslt_s = {opnd0[W-1], opnd0[W-1:1]}; alu_cc_s[0] = opnd0[0]; end
            OP_ROL: begin
                alu_rslt_s  = {opnd0[W-2:0], cc_in[0]};
                alu_cc_s[0] = opnd0[W-1];
                alu_cc_s[1] = opnd0[W-1] ^ opnd0[W-2];
            end
            OP_ROR: begin alu_rslt_s = {cc_in[0], opnd0[W-1:1]}; alu_cc_s[0] = opnd0[0]; end
            OP_MUL: alu_multi_s = 1'b1;
`ifdef JTKCPU_ALUN_DIV_EN
            OP_DIV: begin
                // Divide by zero finishes immediately with a saturated quotient
                if (opnd1 == ZERO_W) begin
                    alu_rslt_s  = {W{1'b1}};
                    alu_hi_s    = opnd0;
                    alu_cc_s[1] = 1'b1;
                    alu_cc_s[0] = 1'b0;
                end else begin
                    alu_multi_s = 1'b1;
                end
            end
`endif
            default: alu_rslt_s = ZERO_W;
        endcase
        alu_cc_s[3] = alu_rslt_s[W-1];
        alu_cc_s[2] = (alu_rslt_s == ZERO_W);
    end

    // Shift-add multiply step on {hi_r, lo_r}; lo_r starts as the multiplier
    always_comb begin
        if (lo_r[0]) begin
            mul_sum_s = {1'b0, hi_r} + {1'b0, mcand_r};
        end else begin
            mul_sum_s = {1'b0, hi_r};
        end
        mul_hi_s    = mul_sum_s[W:1];
        mul_lo_s    = {mul_sum_s[0], lo_r[W-1:1]};
        mul_cc_s    = cc_lat_r;
        mul_cc_s[2] = ({mul_hi_s, mul_lo_s} == {ZERO_W, ZERO_W});
        mul_cc_s[0] = mul_lo_s[W-1];
    end

    // Next iteration state and final flags for the running multi-cycle op
    always_comb begin
        step_hi_s = mul_hi_s;
        step_lo_s = mul_lo_s;
        fin_cc_s  = mul_cc_s;
`ifdef JTKCPU_ALUN_DIV_EN
        div_shift_s = {hi_r, lo_r[W-1]};
        if (div_r) begin
            // Restoring division: hi_r is the partial remainder, lo_r shifts dividend out and quotient in
            if (div_shift_s >= {1'b0, mcand_r}) begin
                step_hi_s = div_shift_s[W-1:0] - mcand_r;
                step_lo_s = {lo_r[W-2:0], 1'b1};
            end else begin
                step_hi_s = div_shift_s[W-1:0];
                step_lo_s = {lo_r[W-2:0], 1'b0};
            end
            fin_cc_s    = cc_lat_r;
            fin_cc_s[3] = step_lo_s[W-1];
            fin_cc_s[2] = (step_lo_s == ZERO_W);
            fin_cc_s[1] = 1'b0;
            fin_cc_s[0] = step_lo_s[0];
        end else begin
            step_hi_s = mul_hi_s;
            step_lo_s = mul_lo_s;
            fin_cc_s  = mul_cc_s;
        end
`endif
    end

    // Request acceptance, iteration and registered results
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            rslt_r    <= ZERO_W;
            rslt_hi_r <= ZERO_W;
            cc_r      <= 8'h00;
            cc_lat_r  <= 8'h00;
            mcand_r   <= ZERO_W;
            hi_r      <= ZERO_W;
            lo_r      <= ZERO_W;
            step_r    <= 5'd0;
`ifdef JTKCPU_ALUN_DIV_EN
            div_r     <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            if (busy_r) begin
                hi_r   <= step_hi_s;
                lo_r   <= step_lo_s;
                step_r <= step_r + 5'd1;
                if (step_r == LAST_STEP) begin
                    busy_r    <= 1'b0;
                    done_r    <= 1'b1;
                    rslt_r    <= step_lo_s;
                    rslt_hi_r <= step_hi_s;
                    cc_r      <= fin_cc_s;
                end
            end else if (start) begin
                if (alu_multi_s) begin
                    busy_r   <= 1'b1;
                    step_r   <= 5'd0;
                    cc_lat_r <= cc_in;
                    hi_r     <= ZERO_W;
`ifdef JTKCPU_ALUN_DIV_EN
                    div_r    <= (op == OP_DIV);
                    if (op == OP_DIV) begin
                        lo_r    <= opnd0;
                        mcand_r <= opnd1;
                    end else begin
                        lo_r    <= opnd1;
                        mcand_r <= opnd0;
                    end
`else
                    lo_r     <= opnd1;
                    mcand_r  <= opnd0;
`endif
                end else begin
                    done_r    <= 1'b1;
                    rslt_r    <= alu_rslt_s;
                    rslt_hi_r <= alu_hi_s;
                    cc_r      <= alu_cc_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_jtkcpu_alun.sv
// Self-checking bench for jtkcpu_alun: W=8 and W=16 instances against an arithmetic reference model.
// Follows JTKCPU_ALUN_DIV_EN so op 19 is expected as DIV or as an undefined op.
module tb_jtkcpu_alun;

    logic        clk = 1'b0;
    logic        rst_n, start8, start16;
    logic [4:0]  op_s;
    logic [15:0] a_s, b_s;
    logic [7:0]  cc_s;
    logic        busy8, done8, busy16, done16;
    logic [7:0]  rslt8, hi8, cc8, cc16;
    logic [15:0] rslt16, hi16;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    jtkcpu_alun #(.W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op(op_s), .opnd0(a_s[7:0]), .opnd1(b_s[7:0]),
        .cc_in(cc_s), .busy(busy8), .done(done8), .rslt(rslt8), .rslt_hi(hi8), .cc_out(cc8)
    );

    jtkcpu_alun #(.W(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .op(op_s), .opnd0(a_s), .opnd1(b_s),
        .cc_in(cc_s), .busy(busy16), .done(done16), .rslt(rslt16), .rslt_hi(hi16), .cc_out(cc16)
    );

    function automatic logic o_done(input int w);
        return (w == 8) ? done8 : done16;
    endfunction
    function automatic logic o_busy(input int w);
        return (w == 8) ? busy8 : busy16;
    endfunction
    function automatic logic [15:0] o_rslt(input int w);
        return (w == 8) ? {8'h00, rslt8} : rslt16;
    endfunction
    function automatic logic [15:0] o_hi(input int w);
        return (w == 8) ? {8'h00, hi8} : hi16;
    endfunction
    function automatic logic [7:0] o_cc(input int w);
        return (w == 8) ? cc8 : cc16;
    endfunction

    // Reference model: integer arithmetic on the operation definitions; lat = edges from accept to done.
    function automatic void ref_model(input int w, input int op, input int a, input int b,
                                      input logic [7:0] cc, output int r, output int rh,
                                      output logic [7:0] co, output int lat);
        int mask, msb, c, s, sa, sb, ss;
        longint p;
        bit nz;
        mask = (1 << w) - 1;
        msb  = 1 << (w - 1);
        c    = cc[0] ? 1 : 0;
        co   = cc;
        r    = 0;
        rh   = 0;
        lat  = 1;
        nz   = 1'b1;
        sa   = (a >= msb) ? a - (1 << w) : a;
        sb   = (b >= msb) ? b - (1 << w) : b;
        case (op)
            0: begin r = a; co[1] = 1'b0; end
            1, 2: begin
                s = a + b + ((op == 2) ? c : 0);
                ss = sa + sb + ((op == 2) ? c : 0);
                r = s & mask;
                co[0] = (s > mask);
                co[1] = (ss >= msb) || (ss < -msb);
                if (w == 8) co[5] = (((a ^ b ^ r) >> 4) & 1) != 0;
            end
            3, 4: begin
                s = a - b - ((op == 4) ? c : 0);
                ss = sa - sb - ((op == 4) ? c : 0);
                r = s & mask;
                co[0] = (s < 0);
                co[1] = (ss >= msb) || (ss < -msb);
            end
            5: begin r = a & b; co[1] = 1'b0; end
            6: begin r = a | b; co[1] = 1'b0; end
            7: begin r = a ^ b; co[1] = 1'b0; end
            8: begin r = (-a) & mask; co[0] = (r != 0); co[1] = (a == msb); end
            9: begin r = (~a) & mask; co[1] = 1'b0; co[0] = 1'b1; end
            10: begin r = 0; co[1] = 1'b0; co[0] = 1'b0; end
            11: begin r = (a + 1) & mask; co[1] = (a == msb - 1); end
            12: begin r = (a - 1) & mask; co[1] = (a == msb); end
            13, 16: begin
                r = ((a << 1) | ((op == 16) ? c : 0)) & mask;
                co[0] = (a & msb) != 0;
                co[1] = ((a & msb) != 0) != ((a & (msb >> 1)) != 0);
            end
            14: begin r = a >> 1; co[0] = (a & 1) != 0; end
            15: begin r = (a >> 1) | (a & msb); co[0] = (a & 1) != 0; end
            17: begin r = (a >> 1) | ((c != 0) ? msb : 0); co[0] = (a & 1) != 0; end
            18: begin
                p = longint'(a) * longint'(b);
                r = int'(p & longint'(mask));
                rh = int'(p >> w);
                co[2] = (p == 0);
                co[0] = (r & msb) != 0;
                lat = w + 1;
                nz = 1'b0;
            end
`ifdef JTKCPU_ALUN_DIV_EN
            19: begin
                if (b == 0) begin
                    r = mask; rh = a; co[1] = 1'b1; co[0] = 1'b0;
                end else begin
                    r = a / b; rh = a % b; co[1] = 1'b0; co[0] = (r & 1) != 0; lat = w + 1;
                end
            end
`endif
            default: begin r = 0; rh = 0; end
        endcase
        if (nz) begin
            co[3] = (r & msb) != 0;
            co[2] = (r == 0);
        end
    endfunction

    // Issue one request and wait (bounded) for done; bok clears if busy misbehaves.
    task automatic exec(input int w, input int op, input int a, input int b, input logic [7:0] cc,
                        output int r, output int rh, output logic [7:0] co, output int lat,
                        output bit bok);
        @(negedge clk);
        op_s = 5'(op);
        a_s  = 16'(a);
        b_s  = 16'(b);
        cc_s = cc;
        if (w == 8) start8 = 1'b1; else start16 = 1'b1;
        @(posedge clk); #1;
        start8  = 1'b0;
        start16 = 1'b0;
        lat = 1;
        bok = 1'b1;
        while (o_done(w) !== 1'b1 && lat < 40) begin
            if (o_busy(w) !== 1'b1) bok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (o_busy(w) !== 1'b0) bok = 1'b0;
        r  = int'(o_rslt(w));
        rh = int'(o_hi(w));
        co = o_cc(w);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start8 = 1'b0; start16 = 1'b0;
        op_s = 5'd0; a_s = 16'h0; b_s = 16'h0; cc_s = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy8, done8, rslt8, hi8, cc8} !== 26'h0) begin
            n_err++; $display("FAIL reset_w8: got %h want 0", {busy8, done8, rslt8, hi8, cc8});
        end
        n_cmp++;
        if ({busy16, done16, rslt16, hi16, cc16} !== 42'h0) begin
            n_err++; $display("FAIL reset_w16: got %h want 0", {busy16, done16, rslt16, hi16, cc16});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        int r, rh, lat, er, erh, elat;
        logic [7:0] co, eco;
        bit bok;
        exec(8, 1, 'h7F, 'h01, 8'h00, r, rh, co, lat, bok);
        ref_model(8, 1, 'h7F, 'h01, 8'h00, er, erh, eco, elat);
        n_cmp++; if (r != 'h80 || lat != 1 || !bok) begin n_err++; $display("FAIL add7f: r=%h lat=%0d bok=%0d want 80/1/1", r, lat, bok); end
        n_cmp++; if ({co[3], co[2], co[1], co[0]} !== 4'b1010) begin n_err++; $display("FAIL add7f_nzvc: got %b want 1010", {co[3], co[2], co[1], co[0]}); end
        n_cmp++; if (co[5] !== eco[5]) begin n_err++; $display("FAIL add7f_h: got %b want %b", co[5], eco[5]); end

        exec(8, 18, 'h0C, 'h0A, 8'h00, r, rh, co, lat, bok);
        n_cmp++; if (r != 'h78 || rh != 0 || lat != 9 || !bok) begin n_err++; $display("FAIL mul8: r=%h hi=%h lat=%0d bok=%0d want 78/00/9/1", r, rh, lat, bok); end
        n_cmp++; if (co[2] !== 1'b0 || co[0] !== 1'b0) begin n_err++; $display("FAIL mul8_zc: got %b%b want 00", co[2], co[0]); end

`ifdef JTKCPU_ALUN_DIV_EN
        exec(8, 19, 'h64, 'h07, 8'h03, r, rh, co, lat, bok);
        n_cmp++; if (r != 'h0E || rh != 'h02 || co[0] !== 1'b0 || co[1] !== 1'b0 || lat != 9) begin n_err++; $display("FAIL div8: r=%h hi=%h c=%b v=%b lat=%0d want 0e/02/0/0/9", r, rh, co[0], co[1], lat); end
        exec(8, 19, 'h55, 'h00, 8'h00, r, rh, co, lat, bok);
        n_cmp++; if (r != 'hFF || rh != 'h55 || co[1] !== 1'b1 || lat != 1 || !bok) begin n_err++; $display("FAIL div0: r=%h hi=%h v=%b lat=%0d want ff/55/1/1", r, rh, co[1], lat); end
`else
        exec(8, 19, 'h64, 'h07, 8'h03, r, rh, co, lat, bok);
        n_cmp++; if (r != 0 || rh != 0 || co !== 8'h07 || lat != 1) begin n_err++; $display("FAIL op19_undef: r=%h hi=%h cc=%h lat=%0d want 00/00/07/1", r, rh, co, lat); end
`endif

        exec(16, 3, 'h0000, 'h0001, 8'h00, r, rh, co, lat, bok);
        n_cmp++; if (r != 'hFFFF || co[0] !== 1'b1 || co[3] !== 1'b1 || co[1] !== 1'b0 || lat != 1) begin n_err++; $display("FAIL sub16: r=%h cc=%h lat=%0d want ffff C=1 N=1 V=0 lat 1", r, co, lat); end
        exec(16, 18, 'hFFFF, 'hFFFF, 8'h00, r, rh, co, lat, bok);
        n_cmp++; if (r != 'h0001 || rh != 'hFFFE || lat != 17 || !bok) begin n_err++; $display("FAIL mul16: r=%h hi=%h lat=%0d bok=%0d want 0001/fffe/17/1", r, rh, lat, bok); end
    endtask

    task automatic test_random(input int w, input int n);
        int op, a, b, mask, r, rh, lat, er, erh, elat;
        logic [7:0] co, eco, cc;
        bit bok;
        mask = (1 << w) - 1;
        for (int i = 0; i < n; i++) begin
            op = ($urandom_range(0, 3) == 0) ? 18 + int'($urandom_range(0, 1)) : int'($urandom_range(0, 31));
            a  = int'($urandom) & mask;
            b  = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom) & mask;
            if ($urandom_range(0, 7) == 0) a = (1 << (w - 1)) - int'($urandom_range(0, 1));
            cc = 8'($urandom);
            ref_model(w, op, a, b, cc, er, erh, eco, elat);
            exec(w, op, a, b, cc, r, rh, co, lat, bok);
            n_cmp++; if (r != er) begin n_err++; $display("FAIL rand_rslt w%0d #%0d op%0d a=%h b=%h: got %h want %h", w, i, op, a, b, r, er); end
            n_cmp++; if (rh != erh) begin n_err++; $display("FAIL rand_hi w%0d #%0d op%0d a=%h b=%h: got %h want %h", w, i, op, a, b, rh, erh); end
            n_cmp++; if (co !== eco) begin n_err++; $display("FAIL rand_cc w%0d #%0d op%0d a=%h b=%h cc=%h: got %h want %h", w, i, op, a, b, cc, co, eco); end
            n_cmp++; if (lat != elat || !bok) begin n_err++; $display("FAIL rand_lat w%0d #%0d op%0d: got %0d bok=%0d want %0d", w, i, op, lat, bok, elat); end
        end
    endtask

    task automatic test_hold();
        int r, rh, lat, er, erh, elat;
        logic [7:0] co, eco;
        bit bok;
        ref_model(8, 2, 'h3A, 'h4C, 8'h21, er, erh, eco, elat);
        exec(8, 2, 'h3A, 'h4C, 8'h21, r, rh, co, lat, bok);
        a_s = 16'h00FF; b_s = 16'h00FF; op_s = 5'd9; cc_s = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (done8 !== 1'b0 || rslt8 !== 8'(er) || hi8 !== 8'(erh) || cc8 !== eco) begin
                n_err++; $display("FAIL hold #%0d: done=%b r=%h hi=%h cc=%h want 0/%h/%h/%h", i, done8, rslt8, hi8, cc8, er, erh, eco);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        bit bok;
        @(negedge clk);
        op_s = 5'd18; a_s = 16'h000C; b_s = 16'h000A; cc_s = 8'h00; start8 = 1'b1;
        @(posedge clk); #1;
        op_s = 5'd1; a_s = 16'h0005; b_s = 16'h0003;
        n = 1; bok = 1'b1;
        while (done8 !== 1'b1 && n < 40) begin
            if (busy8 !== 1'b1) bok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        n_cmp++; if (n != 9 || !bok || rslt8 !== 8'h78 || hi8 !== 8'h00) begin n_err++; $display("FAIL b2b_mul: lat=%0d bok=%0d r=%h hi=%h want 9/1/78/00", n, bok, rslt8, hi8); end
        @(posedge clk); #1;
        n_cmp++; if (done8 !== 1'b1 || busy8 !== 1'b0 || rslt8 !== 8'h08) begin n_err++; $display("FAIL b2b_add: done=%b busy=%b r=%h want 1/0/08", done8, busy8, rslt8); end
        op_s = 5'd18; a_s = 16'h00FF; b_s = 16'h00FF;
        @(posedge clk); #1;
        start8 = 1'b0;
        n = 1; bok = 1'b1;
        while (done8 !== 1'b1 && n < 40) begin
            if (busy8 !== 1'b1) bok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        n_cmp++; if (n != 9 || !bok || rslt8 !== 8'h01 || hi8 !== 8'hFE) begin n_err++; $display("FAIL b2b_mul2: lat=%0d bok=%0d r=%h hi=%h want 9/1/01/fe", n, bok, rslt8, hi8); end
    endtask

    task automatic test_reset_abort();
        bit stray;
        @(negedge clk);
        op_s = 5'd18; a_s = 16'h000C; b_s = 16'h000A; cc_s = 8'h0F; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({busy8, done8, rslt8, hi8, cc8} !== 26'h0) begin
            n_err++; $display("FAIL abort_clear: got %h want 0", {busy8, done8, rslt8, hi8, cc8});
        end
        @(negedge clk);
        rst_n = 1'b1; op_s = 5'd1; a_s = 16'h0011; b_s = 16'h0022; cc_s = 8'h00; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        n_cmp++; if (done8 !== 1'b1 || rslt8 !== 8'h33 || cc8 !== 8'h00) begin n_err++; $display("FAIL first_start: done=%b r=%h cc=%h want 1/33/00", done8, rslt8, cc8); end
        stray = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done8 !== 1'b0 || busy8 !== 1'b0) stray = 1'b1;
        end
        n_cmp++; if (stray) begin n_err++; $display("FAIL abort_stray: got done/busy activity want none"); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random(8, 200);
        test_random(16, 80);
        test_hold();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
